alu_issue_stage: RTL and testbench

//   Operand-issue and write-back stage placed around the combinational ALU.

---
 rtl/alu_issue_stage_if.sv | 51 +++++
 rtl/alu_issue_stage.sv | 118 +++++++++++
 tb/tb_alu_issue_stage.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_stage_if.sv
// Bundle of the issue, ALU, write-back and debug signals of the ALU issue stage.
// Latency: none (wires only).
// Backpressure: in_ready (driven by the stage) throttles in_valid.
interface alu_issue_stage_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 6
);
  // Issue side
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            in_op;
  logic                  in_iscmp;
  logic [REG_ADDR_W-1:0] in_rd;
  logic [REG_ADDR_W-1:0] in_rs0;
  logic [REG_ADDR_W-1:0] in_rs1;
  logic                  in_imm_en;
  logic [DATA_W-1:0]     in_imm;
  logic                  hold;

  // Execute register to and from the combinational ALU
  logic [DATA_W-1:0]     alu_d0;
  logic [DATA_W-1:0]     alu_d1;
  logic [3:0]            alu_op;
  logic                  alu_iscmp;
  logic [DATA_W-1:0]     alu_dout;

  // Write-back report
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0]     wb_data;

  // Debug register read
  logic [REG_ADDR_W-1:0] dbg_raddr;
  logic [DATA_W-1:0]     dbg_rdata;

  // Environment side: decoder, ALU and debug host
  modport master (
    output in_valid, in_op, in_iscmp, in_rd, in_rs0, in_rs1, in_imm_en, in_imm, hold,
    output alu_dout, dbg_raddr,
    input  in_ready, alu_d0, alu_d1, alu_op, alu_iscmp,
    input  wb_valid, wb_rd, wb_data, dbg_rdata
  );

  // Stage side
  modport slave (
    input  in_valid, in_op, in_iscmp, in_rd, in_rs0, in_rs1, in_imm_en, in_imm, hold,
    input  alu_dout, dbg_raddr,
    output in_ready, alu_d0, alu_d1, alu_op, alu_iscmp,
    output wb_valid, wb_rd, wb_data, dbg_rdata
  );
endinterface

// File: rtl/alu_issue_stage.sv
// Operand issue + write-back around a combinational ALU, 64 x 32 regfile with bypass.
// Latency: accepted at edge N, written back at edge N+1; one instruction per cycle.
// Backpressure: hold freezes the execute register and blocks issue (in_ready = !hold).
module alu_issue_stage #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_issue_stage_if.slave   bus
);

  localparam int NREG = 1 << REG_ADDR_W;

  // Architectural register file
  logic [DATA_W-1:0]     regs [NREG];

  // Execute register: the instruction whose operands currently feed the ALU
  logic                  ex_valid;
  logic [DATA_W-1:0]     ex_d0;
  logic [DATA_W-1:0]     ex_d1;
  logic [3:0]            ex_op;
  logic                  ex_iscmp;
  logic [REG_ADDR_W-1:0] ex_rd;

  // Write-back report registers
  logic                  wb_valid_q;
  logic [REG_ADDR_W-1:0] wb_rd_q;
  logic [DATA_W-1:0]     wb_data_q;

  logic                  fire;
  logic                  wb_en;
  logic                  byp0;
  logic                  byp1;
  logic [DATA_W-1:0]     src0;
  logic [DATA_W-1:0]     src1;
  logic [DATA_W-1:0]     opnd1;

  // Issue is blocked only by hold; the stage never stalls on its own.
  assign bus.in_ready = !bus.hold;
  assign fire         = bus.in_valid && !bus.hold;

  // The in-flight instruction retires whenever the pipe is not frozen.
  assign wb_en        = ex_valid && !bus.hold;

  // Forward the ALU result to a back-to-back dependent instruction, since the
  // regfile entry it would read is only written on this same edge.
  always_comb begin
    byp0  = ex_valid && (ex_rd == bus.in_rs0);
    byp1  = ex_valid && (ex_rd == bus.in_rs1);
    src0  = byp0 ? bus.alu_dout : regs[bus.in_rs0];
    src1  = byp1 ? bus.alu_dout : regs[bus.in_rs1];
    opnd1 = bus.in_imm_en ? bus.in_imm : src1;
  end

  // Execute register: load on fire, bubble when idle, freeze under hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_d0    <= '0;
      ex_d1    <= '0;
      ex_op    <= '0;
      ex_iscmp <= 1'b0;
      ex_rd    <= '0;
    end else if (!bus.hold) begin
      if (fire) begin
        ex_valid <= 1'b1;
        ex_d0    <= src0;
        ex_d1    <= opnd1;
        ex_op    <= bus.in_op;
        ex_iscmp <= bus.in_iscmp;
        ex_rd    <= bus.in_rd;
      end else begin
        ex_valid <= 1'b0;
      end
    end
  end

  // Register file: commit the ALU result of the retiring instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en) begin
      regs[ex_rd] <= bus.alu_dout;
    end
  end

  // Write-back report: one-cycle pulse per commit, payload holds in between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= wb_en;
      if (wb_en) begin
        wb_rd_q   <= ex_rd;
        wb_data_q <= bus.alu_dout;
      end
    end
  end

  // ALU inputs come straight from the execute register (no path from in_*).
  assign bus.alu_d0    = ex_d0;
  assign bus.alu_d1    = ex_d1;
  assign bus.alu_op    = ex_op;
  assign bus.alu_iscmp = ex_iscmp;

  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_rd     = wb_rd_q;
  assign bus.wb_data   = wb_data_q;

  // Debug port shows committed state only, never the bypass value.
  assign bus.dbg_rdata = regs[bus.dbg_raddr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage with a behavioural ALU and ISA-level model.
// Latency: checks write-back one edge after acceptance.
// Backpressure: exercises hold both directed and randomly.
module tb_alu_issue_stage;

  logic clk;
  logic rst_n;

  alu_issue_stage_if #(.DATA_W(32), .REG_ADDR_W(6)) bus ();

  alu_issue_stage #(.DATA_W(32), .REG_ADDR_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: op codes for the arithmetic and compare groups.
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic cmp,
                                        input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [31:0]        r;
    sa = a;
    sb = b;
    r  = '0;
    if (cmp) begin
      case (op)
        4'd0:    r = {31'b0, a == b};
        4'd1:    r = {31'b0, a != b};
        4'd2:    r = {31'b0, sa < sb};
        4'd3:    r = {31'b0, a < b};
        default: r = '0;
      endcase
    end else begin
      case (op)
        4'd0:    r = a & b;
        4'd1:    r = a | b;
        4'd2:    r = a ^ b;
        4'd3:    r = a - b;
        4'd4:    r = a + b;
        4'd8:    r = a << b[4:0];
        4'd9:    r = sa >>> b[4:0];
        4'd10:   r = a >> b[4:0];
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  assign bus.alu_dout = alu_f(bus.alu_op, bus.alu_iscmp, bus.alu_d0, bus.alu_d1);

  // Reference model: arch = state after every accepted instruction in program
  // order; comm = state after every reported write-back; pend = accepted but
  // not yet written back.
  typedef struct {
    logic [5:0]  rd;
    logic [31:0] data;
  } wb_t;

  logic [31:0] arch [64];
  logic [31:0] comm [64];
  wb_t         pend [$];

  int checks;
  int failures;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin
      arch[i] = '0;
      comm[i] = '0;
    end
    pend.delete();
  endtask

  task automatic peek(input logic [5:0] a, input logic [31:0] exp, input string tag);
    bus.dbg_raddr = a;
    #1;
    check(tag, bus.dbg_rdata, exp);
  endtask

  // One clock of stimulus, entered and left just after a falling edge.
  task automatic step(input logic v, input logic [3:0] op, input logic cmp,
                      input logic [5:0] rd, input logic [5:0] rs0, input logic [5:0] rs1,
                      input logic ie, input logic [31:0] imm, input logic h);
    logic        exp_wb;
    wb_t         e;
    wb_t         n;
    logic [31:0] b;
    int          ra;
    bus.in_valid  = v;
    bus.in_op     = op;
    bus.in_iscmp  = cmp;
    bus.in_rd     = rd;
    bus.in_rs0    = rs0;
    bus.in_rs1    = rs1;
    bus.in_imm_en = ie;
    bus.in_imm    = imm;
    bus.hold      = h;
    #1;
    check("in_ready", {31'b0, bus.in_ready}, {31'b0, !h});
    @(posedge clk);
    exp_wb = !h && (pend.size() > 0);
    e.rd   = '0;
    e.data = '0;
    if (exp_wb) e = pend.pop_front();
    if (v && !h) begin
      b        = ie ? imm : arch[rs1];
      n.rd     = rd;
      n.data   = alu_f(op, cmp, arch[rs0], b);
      arch[rd] = n.data;
      pend.push_back(n);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("wb_valid", {31'b0, bus.wb_valid}, {31'b0, exp_wb});
    if (exp_wb) begin
      check("wb_rd", {26'b0, bus.wb_rd}, {26'b0, e.rd});
      check("wb_data", bus.wb_data, e.data);
      comm[e.rd] = e.data;
    end
    ra = $urandom_range(0, 63);
    peek(ra[5:0], comm[ra], "dbg_rdata");
  endtask

  task automatic idle(input logic h);
    step(1'b0, 4'd0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0, 32'd0, h);
  endtask

  // Reset asserted just after a falling edge, held across one rising edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
    check("rst_alu_d0", bus.alu_d0, 32'd0);
    check("rst_alu_d1", bus.alu_d1, 32'd0);
    check("rst_alu_op", {28'b0, bus.alu_op}, 32'd0);
    check("rst_alu_iscmp", {31'b0, bus.alu_iscmp}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  initial begin
    logic [3:0] ops [12];
    logic [3:0] op;
    logic       cmp;
    int         k;

    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_iscmp  = 1'b0;
    bus.in_rd     = '0;
    bus.in_rs0    = '0;
    bus.in_rs1    = '0;
    bus.in_imm_en = 1'b0;
    bus.in_imm    = '0;
    bus.hold      = 1'b0;
    bus.dbg_raddr = '0;
    model_clear();

    // 1: reset state
    repeat (2) @(negedge clk);
    do_reset();
    check("t1_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
    check("t1_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("t1_wb_rd", {26'b0, bus.wb_rd}, 32'd0);
    check("t1_wb_data", bus.wb_data, 32'd0);
    for (int i = 0; i < 64; i++) peek(i[5:0], 32'd0, "t1_sweep");

    // 2: immediates then a spaced register-register add
    @(negedge clk);
    step(1'b1, 4'd4, 1'b0, 6'd1, 6'd0, 6'd0, 1'b1, 32'd3, 1'b0);
    step(1'b1, 4'd4, 1'b0, 6'd2, 6'd0, 6'd0, 1'b1, 32'd7, 1'b0);
    idle(1'b0);
    idle(1'b0);
    step(1'b1, 4'd4, 1'b0, 6'd3, 6'd1, 6'd2, 1'b0, 32'd0, 1'b0);
    idle(1'b0);
    check("t2_wb_valid", {31'b0, bus.wb_valid}, 32'd1);
    check("t2_wb_rd", {26'b0, bus.wb_rd}, 32'd3);
    check("t2_wb_data", bus.wb_data, 32'd10);
    peek(6'd3, 32'd10, "t2_r3");

    // 3: back-to-back dependency through the bypass
    step(1'b1, 4'd4, 1'b0, 6'd1, 6'd0, 6'd0, 1'b1, -32'sd1024, 1'b0);
    step(1'b1, 4'd9, 1'b0, 6'd4, 6'd1, 6'd0, 1'b1, 32'd8, 1'b0);
    idle(1'b0);
    peek(6'd4, 32'hFFFF_FFFC, "t3_r4");
    peek(6'd1, 32'hFFFF_FC00, "t3_r1");

    // 4: compares
    step(1'b1, 4'd2, 1'b1, 6'd5, 6'd3, 6'd0, 1'b1, 32'd11, 1'b0);
    idle(1'b0);
    peek(6'd5, 32'd1, "t4_lt");
    step(1'b1, 4'd0, 1'b1, 6'd5, 6'd3, 6'd0, 1'b1, 32'd9, 1'b0);
    idle(1'b0);
    peek(6'd5, 32'd0, "t4_eq");

    // 5: hold freezes the in-flight instruction, release retires it once
    step(1'b1, 4'd8, 1'b0, 6'd6, 6'd3, 6'd0, 1'b1, 32'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'd4, 1'b0, 6'd7, 6'd0, 6'd0, 1'b1, 32'd99, 1'b1);
      check("t5_held_wb", {31'b0, bus.wb_valid}, 32'd0);
    end
    peek(6'd6, 32'd0, "t5_r6_held");
    idle(1'b0);
    check("t5_wb_valid", {31'b0, bus.wb_valid}, 32'd1);
    check("t5_wb_data", bus.wb_data, 32'd40);
    idle(1'b0);
    check("t5_single_pulse", {31'b0, bus.wb_valid}, 32'd0);
    peek(6'd6, 32'd40, "t5_r6");
    peek(6'd7, 32'd0, "t5_r7_blocked");

    // 6: reset right after issue discards the instruction
    step(1'b1, 4'd4, 1'b0, 6'd7, 6'd0, 6'd0, 1'b1, 32'd5, 1'b0);
    do_reset();
    idle(1'b0);
    check("t6_no_wb", {31'b0, bus.wb_valid}, 32'd0);
    peek(6'd7, 32'd0, "t6_r7");
    peek(6'd6, 32'd0, "t6_r6");

    // Random traffic on a small register window for dense dependencies
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10, 4'd0, 4'd1, 4'd2, 4'd3};
    for (int i = 0; i < 600; i++) begin
      k   = $urandom_range(0, 11);
      op  = ops[k];
      cmp = (k >= 8);
      step(($urandom_range(0, 3) != 0), op, cmp,
           6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), $urandom(), ($urandom_range(0, 4) == 0));
    end
    idle(1'b0);
    idle(1'b0);
    for (int i = 0; i < 64; i++) peek(i[5:0], arch[i], "final_sweep");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
